// File: rtl/linebuffer_window9.sv
// Streaming 9x9 window generator: 8 line buffers feed a 9x9 shift-register window,
// with raster position tracking so only windows fully inside the current frame are flagged.
module linebuffer_window9 #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int PIX_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_pix,
  output logic [PIX_W-1:0] xarray [0:80],
  output logic             win_valid,
  output logic             win_last
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_WIN = XW'(8);
  localparam logic [YW-1:0] Y_WIN = YW'(8);

  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic [XW-1:0]    px;
  logic [YW-1:0]    py;
  logic [PIX_W-1:0] lb  [0:7][0:IMG_W-1];
  logic [PIX_W-1:0] col [0:8];

  // Position of the pixel offered this cycle; a start-of-frame forces it to (0,0).
  always_comb begin
    px = in_sof ? '0 : x;
    py = in_sof ? '0 : y;
  end

  // lb[k] holds row (y-1-k) at columns not yet overwritten in the current row.
  always_comb begin
    for (int r = 0; r < 8; r++) begin
      col[r] = lb[7-r][px];
    end
    col[8] = in_pix;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (in_valid) begin
      if (px == X_MAX) begin
        x <= '0;
        y <= (py == Y_MAX) ? '0 : py + 1'b1;
      end else begin
        x <= px + 1'b1;
        y <= py;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && in_valid) begin
      lb[0][px] <= in_pix;
      for (int k = 1; k < 8; k++) begin
        lb[k][px] <= lb[k-1][px];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 81; i++) begin
        xarray[i] <= '0;
      end
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end else begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      if (in_valid) begin
        for (int r = 0; r < 9; r++) begin
          for (int c = 0; c < 8; c++) begin
            xarray[r*9+c] <= xarray[r*9+c+1];
          end
          xarray[r*9+8] <= col[r];
        end
        win_valid <= (px >= X_WIN) && (py >= Y_WIN);
        win_last  <= (px == X_MAX) && (py == Y_MAX);
      end
    end
  end

endmodule
